// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter with a one-entry holding buffer; parity (i_Parity_Mode, PARITY state) enabled by UART_TX_PARITY_EN
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]           i_Parity_Mode,
`endif
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d;
  logic [DATA_BITS-1:0] shift, shift_d, buf_data;
  logic buf_full, accept, load, bit_end, last_stop;
`ifdef UART_TX_PARITY_EN
  logic [1:0] mode, buf_mode;
  logic par_bit, has_par;
  assign has_par = mode[0] ^ mode[1];
`endif
  assign accept = i_TX_DV & ~buf_full;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign last_stop = state == STOP && bit_end && idx == IW'(STOP_BITS - 1);
  assign load = buf_full && (state == IDLE || last_stop);
  assign o_TX_Ready = ~buf_full;
  assign o_TX_Done = last_stop;
  assign o_TX_Active = state == START || state == DATA || state == STOP
`ifdef UART_TX_PARITY_EN
    || state == PARITY
`endif
    ;
`ifdef UART_TX_PARITY_EN
  assign o_TX_Serial = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_bit : 1'b1;
`else
  assign o_TX_Serial = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
`endif
  // holding buffer: filled only while empty, drained when a frame starts
  always_ff @(posedge i_Clock or negedge i_Rst_L)
    if (!i_Rst_L) begin
      buf_full <= 1'b0;
      buf_data <= '0;
`ifdef UART_TX_PARITY_EN
      buf_mode <= 2'b00;
`endif
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= i_TX_Byte;
`ifdef UART_TX_PARITY_EN
      buf_mode <= i_Parity_Mode;
`endif
    end else if (load) begin
      buf_full <= 1'b0;
    end
  always_ff @(posedge i_Clock or negedge i_Rst_L)
    if (!i_Rst_L) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
`ifdef UART_TX_PARITY_EN
      mode <= 2'b00;
      par_bit <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      shift <= shift_d;
`ifdef UART_TX_PARITY_EN
      if (load) begin
        mode <= buf_mode;
        par_bit <= ^buf_data ^ buf_mode[1];
      end
`endif
    end
  always_comb begin
    state_d = state;
    cnt_d = bit_end ? '0 : cnt + 1'b1;
    idx_d = idx;
    shift_d = shift;
    case (state)
      IDLE: begin
        cnt_d = '0;
        state_d = load ? START : IDLE;
        shift_d = load ? buf_data : shift;
      end
      START: state_d = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_d = shift >> 1;
        idx_d = idx == IW'(DATA_BITS - 1) ? '0 : idx + 1'b1;
`ifdef UART_TX_PARITY_EN
        state_d = idx == IW'(DATA_BITS - 1) ? (has_par ? PARITY : STOP) : DATA;
`else
        state_d = idx == IW'(DATA_BITS - 1) ? STOP : DATA;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_d = bit_end ? STOP : PARITY;
`endif
      STOP: if (bit_end) begin
        idx_d = last_stop ? '0 : idx + 1'b1;
        state_d = last_stop ? (load ? START : IDLE) : STOP;
        shift_d = last_stop && load ? buf_data : shift;
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: per-cycle waveform model of two UART configurations (8N1 and 7-bit/2-stop), directed plus random frames
module tb_uart_tx_param;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct packed {logic ser; logic done;} cyc_t;
  logic clk = 1'b0, rst_l = 1'b0, dv = 1'b0, sel = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] mode = 2'b00;
  logic [1:0] rdy, act, ser, dn;
  cyc_t wq[$], mbuf[$];
  logic mbuf_full = 1'b0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv & ~sel), .i_TX_Byte(data),
`ifdef UART_TX_PARITY_EN
    .i_Parity_Mode(mode),
`endif
    .o_TX_Ready(rdy[0]), .o_TX_Active(act[0]), .o_TX_Serial(ser[0]), .o_TX_Done(dn[0]));
  uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .i_Clock(clk), .i_Rst_L(rst_l), .i_TX_DV(dv & sel), .i_TX_Byte(data[6:0]),
`ifdef UART_TX_PARITY_EN
    .i_Parity_Mode(mode),
`endif
    .o_TX_Ready(rdy[1]), .o_TX_Active(act[1]), .o_TX_Serial(ser[1]), .o_TX_Done(dn[1]));
  task automatic chk(input string tag, input logic o, input logic e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s @%0t: got %b want %b", tag, $time, o, e);
    end
  endtask
  // expand one frame into its per-cycle serial level and done flag
  task automatic stage(input logic [7:0] d, input logic [1:0] m);
    int nb = sel ? 7 : 8;
    int ns = sel ? 2 : 1;
    logic b[$];
    logic p;
    b.push_back(1'b0);
    p = (m == 2'b10);
    for (int i = 0; i < nb; i++) begin
      b.push_back(d[i]);
      p ^= d[i];
    end
    if (PAR && (m == 2'b01 || m == 2'b10)) b.push_back(p);
    repeat (ns) b.push_back(1'b1);
    mbuf.delete();
    foreach (b[k])
      for (int j = 0; j < C; j++) mbuf.push_back(cyc_t'{b[k], (k == b.size() - 1) && (j == C - 1)});
  endtask
  task automatic tick(input logic v, input logic [7:0] d, input logic [1:0] m);
    logic old;
    @(negedge clk);
    chk("serial", ser[sel], wq.size() > 0 ? wq[0].ser : 1'b1);
    chk("done", dn[sel], wq.size() > 0 ? wq[0].done : 1'b0);
    chk("active", act[sel], wq.size() > 0);
    chk("ready", rdy[sel], !mbuf_full);
    dv = v;
    data = d;
    mode = m;
    @(posedge clk);
    old = mbuf_full;
    if (wq.size() > 0) void'(wq.pop_front());
    if (old && wq.size() == 0) begin
      wq = mbuf;
      mbuf_full = 1'b0;
    end
    if (v && !old) begin
      stage(d, m);
      mbuf_full = 1'b1;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00, 2'b00);
  endtask
  task automatic rst_chk(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk({tag, ":serial"}, ser[u], 1'b1);
      chk({tag, ":active"}, act[u], 1'b0);
      chk({tag, ":ready"}, rdy[u], 1'b1);
      chk({tag, ":done"}, dn[u], 1'b0);
    end
  endtask
  initial begin
    #12 rst_chk("reset");
    @(negedge clk) rst_l = 1'b1;
    tick(1'b1, 8'hA5, 2'b00);
    idle(45);
    tick(1'b1, 8'h07, 2'b01);
    idle(50);
    tick(1'b1, 8'h07, 2'b10);
    idle(50);
    tick(1'b1, 8'h55, 2'b00);
    idle(10);
    tick(1'b1, 8'h0F, 2'b00);
    idle(5);
    tick(1'b1, 8'hFF, 2'b11);
    idle(90);
    repeat (200) tick($urandom_range(7) == 0, 8'($urandom), 2'($urandom));
    idle(100);
    tick(1'b1, 8'h3C, 2'b00);
    idle(1 + C + 3 * C + 1);
    tick(1'b1, 8'h99, 2'b00);
    idle(2);
    @(negedge clk) rst_l = 1'b0;
    #1 rst_chk("midreset");
    wq.delete();
    mbuf_full = 1'b0;
    @(negedge clk) rst_l = 1'b1;
    idle(60);
    @(negedge clk) sel = 1'b1;
    tick(1'b1, 8'h41, 2'b00);
    idle(45);
    repeat (150) tick($urandom_range(5) == 0, 8'($urandom), 2'($urandom));
    idle(100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clocks per serial bit; legal values are 2 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range is 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values are 1 and 2.
REQ-004 SHALL have port i_Clock, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_TX_DV, input, 1 bit: byte valid, one-cycle strobe.
REQ-007 SHALL have port i_TX_Byte, input, DATA_BITS bits: data to send, LSB transmitted first.
REQ-008 SHALL have port i_Parity_Mode, input, 2 bits: 00 none, 01 even, 10 odd, 11 none; present only per REQ-031.
REQ-009 SHALL have port o_TX_Ready, output, 1 bit: holding buffer empty, so a byte can be accepted.
REQ-010 SHALL have port o_TX_Active, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port o_TX_Serial, output, 1 bit: serial line, idles high.
REQ-012 SHALL have port o_TX_Done, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-013 SHALL accept a byte into a one-entry holding buffer at a rising edge where i_TX_DV=1 and o_TX_Ready=1; the same edge also latches i_Parity_Mode; o_TX_Ready goes to 0 after that edge.
REQ-014 SHALL ignore i_TX_DV while o_TX_Ready=0: no overwrite and no error.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP; every state is registered.
REQ-016 In IDLE with the buffer full, at the next edge the FSM SHALL:
- move the buffer into the shift register;
- enter START;
- drive o_TX_Serial=0;
- set o_TX_Active=1;
- set o_TX_Ready=1.
REQ-017 Latency SHALL be exactly one cycle: the start bit appears on the edge after the accepting edge.
REQ-018 Each bit SHALL last exactly CLKS_PER_BIT cycles; the bit counter is wide enough for CLKS_PER_BIT-1 and clears at each bit boundary.
REQ-019 Transitions SHALL be:
- START to DATA after one bit time.
- DATA SHALL send DATA_BITS bits, LSB first; the data-bit index wraps to 0 on leaving DATA.
- After the last data bit, DATA goes to PARITY if the latched mode is 01 or 10, otherwise to STOP.
- PARITY lasts one bit time; for even mode the bit is the XOR of the data bits, for odd mode it is the inverse.
- STOP SHALL drive 1 for STOP_BITS bit times.
REQ-020 On the last cycle of STOP the block SHALL pulse o_TX_Done=1 for one cycle.
REQ-021 If the buffer is full on the last cycle of STOP, the block SHALL go directly to START:
- no idle cycle between frames;
- o_TX_Active stays 1;
- the buffer is loaded as in REQ-016.
REQ-022 If the buffer is empty on the last cycle of STOP, the block SHALL enter IDLE with o_TX_Active=0 and o_TX_Serial=1.
REQ-023 A byte accepted during a frame SHALL be held until that frame ends; it SHALL never corrupt the shift register or the latched parity mode.
REQ-024 An illegal or unreachable state SHALL recover to IDLE on the next edge with o_TX_Serial=1.

Reset
REQ-025 While i_Rst_L=0 the block SHALL force o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0 and o_TX_Ready=1, asynchronously.
REQ-026 Reset SHALL clear the FSM to IDLE and zero the bit counter, bit index, shift register and latched parity mode.
REQ-027 Reset SHALL empty the holding buffer.
REQ-028 Reset asserted mid-frame SHALL abort the frame and discard any pending byte, with no o_TX_Done pulse.
REQ-029 After i_Rst_L deasserts, a byte SHALL be accepted on the first edge with i_TX_DV=1.

Configuration
REQ-030 Parity support SHALL be controlled by the macro UART_TX_PARITY_EN.
REQ-031 With UART_TX_PARITY_EN defined, the block SHALL have port i_Parity_Mode and state PARITY, behaving per REQ-019.
REQ-032 Without UART_TX_PARITY_EN, the block SHALL omit port i_Parity_Mode and state PARITY, and frames SHALL never carry a parity bit.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-033 Send 0xA5, DATA_BITS=8, mode 00 -> serial 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; o_TX_Done pulses 40 cycles after the start bit begins.
REQ-034 Send 0x07 with mode 01 -> parity bit 1; send 0x07 with mode 10 -> parity bit 0; each frame is 44 cycles.
REQ-035 Accept 0x55, then strobe 0x0F at cycle 10 -> o_TX_Ready=0 from cycle 11 until the second load; o_TX_Active stays high; no idle gap; two o_TX_Done pulses 40 cycles apart.
REQ-036 DATA_BITS=7, STOP_BITS=2, send 0x41 -> serial 0,1,0,0,0,0,0,1,1,1; frame lasts 40 cycles.
REQ-037 Assert reset in DATA bit 3 with a byte pending -> o_TX_Serial=1, o_TX_Active=0 and o_TX_Ready=1 immediately; no o_TX_Done pulse; the pending byte is never sent.
REQ-038 Strobe i_TX_DV=1 with 0xFF while o_TX_Ready=0 -> the byte is ignored and the frames in flight are unchanged.
